// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, issues fixed-latency ROM reads under a
// credit check, and buffers returned words in a FIFO that feeds ID via valid/stall.
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rom_data_i,
  output logic [ADDR_W-1:0]        rom_addr_o,
  output logic                     rom_ce_o,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     id_valid_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [DATA_W-1:0]        id_inst_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]               pc_q;
  logic [ROM_LAT:1]                vld_pipe_q;
  logic [ROM_LAT:1][ADDR_W-1:0]    pc_pipe_q;
  logic [DEPTH-1:0][ADDR_W-1:0]    fifo_pc_q;
  logic [DEPTH-1:0][DATA_W-1:0]    fifo_inst_q;
  logic [PW-1:0]                   head_q, tail_q;
  logic [CW-1:0]                   count_q;

  logic [CW:0] inflight;
  logic        issue, push, pop;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= ROM_LAT; k++) inflight += {{CW{1'b0}}, vld_pipe_q[k]};
  end

  // Credit uses start-of-cycle occupancy, so a return can never find the FIFO full.
  assign issue = !flush_i && (({1'b0, count_q} + inflight) < (CW+1)'(DEPTH));
  assign push  = vld_pipe_q[ROM_LAT] && !flush_i;
  assign pop   = id_valid_o && !stall_i && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      vld_pipe_q <= '0;
      pc_pipe_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (flush_i) begin
      pc_q       <= redirect_pc_i;
      vld_pipe_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      if (issue) pc_q <= pc_q + ADDR_W'(PC_STEP);
      vld_pipe_q[1] <= issue;
      pc_pipe_q[1]  <= pc_q;
      for (int k = 2; k <= ROM_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        pc_pipe_q[k]  <= pc_pipe_q[k-1];
      end
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: it is only observable while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail_q]   <= pc_pipe_q[ROM_LAT];
      fifo_inst_q[tail_q] <= rom_data_i;
    end
  end

  assign rom_addr_o   = pc_q;
  assign rom_ce_o     = rst && issue;
  assign id_valid_o   = (count_q != '0);
  assign id_pc_o      = id_valid_o ? fifo_pc_q[head_q]   : '0;
  assign id_inst_o    = id_valid_o ? fifo_inst_q[head_q] : '0;
  assign fifo_count_o = count_q;
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: three configurations share stimulus; a queue-based transaction
// model checks every cycle, plus directed tables and flush/reset sequences on config 0.
module tb_if_prefetch;
  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 3, 3};
  localparam int DEP [NI] = '{4, 8, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] redir = '0;

  wire        t_ce   [NI];
  wire        t_vld  [NI];
  wire [31:0] t_addr [NI];
  wire [31:0] t_pc   [NI];
  wire [31:0] t_inst [NI];
  wire [31:0] t_cnt  [NI];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int D  = (g == 1) ? 8 : 4;
    localparam int CW = $clog2(D) + 1;
    logic [31:0]   addr, data, idpc, idinst;
    logic          ce, vld;
    logic [CW-1:0] cnt;
    logic [31:0]   ap [L];

    // ROM: data = ~address, L cycles after the address was presented
    always @(posedge clk) begin
      ap[0] <= addr;
      for (int k = 1; k < L; k++) ap[k] <= ap[k-1];
    end
    assign data = ~ap[L-1];

    if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .ROM_LAT(L),
                  .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
      .clk(clk), .rst(rst), .rom_data_i(data), .rom_addr_o(addr), .rom_ce_o(ce),
      .stall_i(stall), .flush_i(flush), .redirect_pc_i(redir),
      .id_valid_o(vld), .id_pc_o(idpc), .id_inst_o(idinst), .fifo_count_o(cnt));

    assign t_ce[g]   = ce;
    assign t_vld[g]  = vld;
    assign t_addr[g] = addr;
    assign t_pc[g]   = idpc;
    assign t_inst[g] = idinst;
    assign t_cnt[g]  = 32'(cnt);
  end

  // Transaction model: FIFO contents, outstanding requests with return cycle, fetch PC
  logic [31:0] mq     [NI][$];
  logic [31:0] mi_pc  [NI][$];
  int          mi_ret [NI][$];
  logic [31:0] mpc    [NI];
  int          cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic m_ce(int i);
    return !flush && ((mq[i].size() + mi_pc[i].size()) < DEP[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete(); mi_pc[i].delete(); mi_ret[i].delete();
      mpc[i] = 32'h0;
    end
    cyc = 0;
  endtask

  task automatic model_step();
    logic ce;
    for (int i = 0; i < NI; i++) begin
      ce = m_ce(i);
      if (flush) begin
        mq[i].delete(); mi_pc[i].delete(); mi_ret[i].delete();
        mpc[i] = redir;
      end else begin
        if (mq[i].size() != 0 && !stall) void'(mq[i].pop_front());
        if (mi_pc[i].size() != 0 && mi_ret[i][0] == cyc) begin
          mq[i].push_back(mi_pc[i].pop_front());
          void'(mi_ret[i].pop_front());
        end
        if (ce) begin
          mi_pc[i].push_back(mpc[i]);
          mi_ret[i].push_back(cyc + LAT[i]);
          mpc[i] = mpc[i] + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic drive_chk(input logic st, input logic fl, input logic [31:0] rd);
    logic        v;
    logic [31:0] hp;
    @(negedge clk);
    stall = st; flush = fl; redir = rd;
    #1;
    for (int i = 0; i < NI; i++) begin
      v  = (mq[i].size() != 0);
      hp = v ? mq[i][0] : 32'h0;
      chk($sformatf("u%0d c%0d rom_ce", i, cyc),   32'(t_ce[i]),  32'(m_ce(i)));
      chk($sformatf("u%0d c%0d rom_addr", i, cyc), t_addr[i],     mpc[i]);
      chk($sformatf("u%0d c%0d id_valid", i, cyc), 32'(t_vld[i]), 32'(v));
      chk($sformatf("u%0d c%0d id_pc", i, cyc),    t_pc[i],       hp);
      chk($sformatf("u%0d c%0d id_inst", i, cyc),  t_inst[i],     v ? ~hp : 32'h0);
      chk($sformatf("u%0d c%0d count", i, cyc),    t_cnt[i],      32'(mq[i].size()));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  // Asserts reset between clock edges and checks outputs clear without waiting for a clock
  task automatic do_reset();
    #2;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d reset rom_ce", i),   32'(t_ce[i]),  32'h0);
      chk($sformatf("u%0d reset id_valid", i), 32'(t_vld[i]), 32'h0);
      chk($sformatf("u%0d reset count", i),    t_cnt[i],      32'h0);
      chk($sformatf("u%0d reset id_pc", i),    t_pc[i],       32'h0);
      chk($sformatf("u%0d reset id_inst", i),  t_inst[i],     32'h0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic run_flush(input int nstall, input logic st_in_flush, input int exp_cnt);
    do_reset();
    for (int c = 0; c < nstall; c++) begin drive_chk(1'b1, 1'b0, 32'h0); tick(); end
    drive_chk(st_in_flush, 1'b1, 32'h100);
    chk("flush pre count", t_cnt[0], 32'(exp_cnt));
    chk("flush cycle rom_ce", 32'(t_ce[0]), 32'h0);
    tick();
    drive_chk(1'b0, 1'b0, 32'h0);
    chk("post-flush id_valid", 32'(t_vld[0]), 32'h0);
    chk("post-flush count", t_cnt[0], 32'h0);
    chk("post-flush rom_addr", t_addr[0], 32'h100);
    chk("post-flush rom_ce", 32'(t_ce[0]), 32'h1);
    tick();
    drive_chk(1'b0, 1'b0, 32'h0);
    chk("post-flush+1 id_valid", 32'(t_vld[0]), 32'h0);
    tick();
    drive_chk(1'b0, 1'b0, 32'h0);
    chk("first redirected id_pc", t_pc[0], 32'h100);
    chk("first redirected id_inst", t_inst[0], ~32'h100);
    tick();
    drive_chk(1'b0, 1'b0, 32'h0);
    chk("second redirected id_pc", t_pc[0], 32'h104);
    tick();
  endtask

  typedef struct packed {
    logic        rs;
    logic        st;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        ce;
    logic [31:0] addr;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    int   c;
    logic s, f;
    logic [31:0] rd;

    // Stream from reset (config 0): first valid in cycle 2, one per cycle
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 32'h4};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'd1, 1'b1, 32'h8};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h4,  32'd1, 1'b1, 32'hC};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h8,  32'd1, 1'b1, 32'h10};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'hC,  32'd1, 1'b1, 32'h14};
    // Backpressure from reset: ten stalled cycles, then drain in order
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 32'h4};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h0,  32'd1, 1'b1, 32'h8};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h0,  32'd2, 1'b1, 32'hC};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'd3, 1'b0, 32'h10};
    for (int r = 11; r < 16; r++) tbl[r] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'd4, 1'b0, 32'h10};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'd4, 1'b0, 32'h10};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h4,  32'd3, 1'b1, 32'h10};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 32'h8,  32'd2, 1'b1, 32'h14};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 32'hC,  32'd2, 1'b1, 32'h18};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'd2, 1'b1, 32'h1C};

    model_reset();
    c = 0;
    for (int r = 0; r < NV; r++) begin
      if (tbl[r].rs) begin do_reset(); c = 0; end
      drive_chk(tbl[r].st, 1'b0, 32'h0);
      chk($sformatf("tbl%0d id_valid", r), 32'(t_vld[0]), 32'(tbl[r].vld));
      chk($sformatf("tbl%0d id_pc", r),    t_pc[0],       tbl[r].pc);
      chk($sformatf("tbl%0d id_inst", r),  t_inst[0],     tbl[r].vld ? ~tbl[r].pc : 32'h0);
      chk($sformatf("tbl%0d count", r),    t_cnt[0],      tbl[r].cnt);
      chk($sformatf("tbl%0d rom_ce", r),   32'(t_ce[0]),  32'(tbl[r].ce));
      chk($sformatf("tbl%0d rom_addr", r), t_addr[0],     tbl[r].addr);
      if (c >= 4) chk($sformatf("tbl%0d lat3 id_valid", r), 32'(t_vld[1]), 32'h1);
      tick();
      c++;
    end

    run_flush(4, 1'b0, 3);   // 3 buffered + 1 in flight
    run_flush(5, 1'b1, 4);   // full FIFO, stall asserted with flush

    do_reset();
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 24) == 0);
      rd = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if (n == 40) begin f = 1'b1; rd = 32'hFFFF_FFF8; end
      if (n == 200) do_reset();
      drive_chk(s, f, rd);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
